// File: rtl/overdrive_pkg.sv
// Shared definitions for the overdrive pipeline.
// Contents:
//   - width constants for sample, gain, channel tag and clip counter
//   - od_mode_e limiting mode enum
//   - stage payload structs carried by the S1 and S2 registers
//   - sat_limits: clamps a widened value to the sample range and flags clamping
package overdrive_pkg;

    localparam int DATA_W = 16;
    localparam int GAIN_W = 8;
    localparam int FRAC_W = 4;
    localparam int CHAN_W = 1;
    localparam int CNT_W  = 16;

    // Product of a signed sample and a zero-extended unsigned gain.
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    // One extra bit so the knee arithmetic (p - T, T + ...) cannot overflow.
    localparam int KNEE_W = PROD_W + 1;

    typedef enum logic [1:0] {
        OD_BYPASS = 2'd0,
        OD_HARD   = 2'd1,
        OD_SOFT   = 2'd2,
        OD_RSVD   = 2'd3
    } od_mode_e;

    typedef struct packed {
        logic signed [DATA_W-1:0] sample;
        logic [CHAN_W-1:0]        chan;
        od_mode_e                 mode;
        logic [GAIN_W-1:0]        gain;
        logic [DATA_W-2:0]        thresh;
    } s1_payload_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] prod;
        logic signed [DATA_W-1:0] sample;
        logic [CHAN_W-1:0]        chan;
        od_mode_e                 mode;
        logic [DATA_W-2:0]        thresh;
    } s2_payload_t;

    localparam logic signed [KNEE_W-1:0] SAT_MAX = KNEE_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [KNEE_W-1:0] SAT_MIN = ~SAT_MAX;

    // Returns {saturated_flag, clamped_value}.
    function automatic logic [DATA_W:0] sat_limits(input logic signed [KNEE_W-1:0] v);
        logic [DATA_W:0] r;
        if (v > SAT_MAX) begin
            r = {1'b1, SAT_MAX[DATA_W-1:0]};
        end else if (v < SAT_MIN) begin
            r = {1'b1, SAT_MIN[DATA_W-1:0]};
        end else begin
            r = {1'b0, v[DATA_W-1:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/od_limiter.sv
// Combinational limiter used by the third pipeline stage.
// Applies the optional soft knee to the scaled product, then saturates to the
// sample range. Bypass mode passes the original sample through untouched.
// Ports:
//   prod   in   scaled product (already shifted down by FRAC_W)
//   sample in   original input sample, used only in bypass
//   thresh in   soft-knee threshold magnitude
//   mode   in   limiting mode
//   value  out  limited, saturated output sample
//   sat    out  high when final saturation clamped the value
module od_limiter
    import overdrive_pkg::*;
(
    input  logic signed [PROD_W-1:0] prod,
    input  logic signed [DATA_W-1:0] sample,
    input  logic [DATA_W-2:0]        thresh,
    input  od_mode_e                 mode,
    output logic [DATA_W-1:0]        value,
    output logic                     sat
);

    logic signed [KNEE_W-1:0] p;
    logic signed [KNEE_W-1:0] t;
    logic signed [KNEE_W-1:0] knee;
    logic [DATA_W:0]          limited;

    // Above the knee the excess over T is halved (floor), symmetric for negatives.
    // The reserved mode falls through to plain hard clipping.
    always_comb begin
        p    = KNEE_W'(prod);
        t    = KNEE_W'(thresh);
        knee = p;
        if (mode == OD_SOFT) begin
            if (p > t) begin
                knee = t + ((p - t) >>> 1);
            end else if (p < -t) begin
                knee = -t + ((p + t) >>> 1);
            end
        end
        limited = sat_limits(knee);
        value   = limited[DATA_W-1:0];
        sat     = limited[DATA_W];
        if (mode == OD_BYPASS) begin
            value = sample;
            sat   = 1'b0;
        end
    end

endmodule

// File: rtl/overdrive_pipe.sv
// Streaming overdrive stage: gain, optional soft knee or hard clip, saturation.
// Three register stages with valid/ready flow control; each stage advances
// when its successor is empty or advancing, so bubbles are squeezed out.
// Ports:
//   clk, reset_n           clock and synchronous active-low reset
//   mode, gain, thresh     per-sample configuration, captured with each sample
//   in_valid/in_ready      input handshake; in_sample, in_chan input payload
//   out_valid/out_ready    output handshake; out_sample, out_chan output payload
//   clip_count             saturating count of output transfers that were clamped
//   clr_stats              synchronous clear of clip_count (wins over increment)
module overdrive_pipe
    import overdrive_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic [GAIN_W-1:0] gain,
    input  logic [DATA_W-2:0] thresh,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sample,
    input  logic [CHAN_W-1:0] in_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sample,
    output logic [CHAN_W-1:0] out_chan,
    output logic [CNT_W-1:0]  clip_count,
    input  logic              clr_stats
);

    logic        v1;
    logic        v2;
    logic        en1;
    logic        en2;
    logic        en3;
    s1_payload_t s1;
    s2_payload_t s2;
    logic        out_sat;

    logic signed [PROD_W-1:0] samp_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod_full;
    logic signed [PROD_W-1:0] prod_shr;

    logic [DATA_W-1:0] lim_value;
    logic              lim_sat;

    assign en3      = !out_valid || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1;

    // Gain is unsigned, so it is zero-extended before the signed multiply;
    // the arithmetic shift floors toward minus infinity.
    assign samp_ext  = PROD_W'(s1.sample);
    assign gain_ext  = PROD_W'(s1.gain);
    assign prod_full = samp_ext * gain_ext;
    assign prod_shr  = prod_full >>> FRAC_W;

    od_limiter u_limiter (
        .prod   (s2.prod),
        .sample (s2.sample),
        .thresh (s2.thresh),
        .mode   (s2.mode),
        .value  (lim_value),
        .sat    (lim_sat)
    );

    // Stage registers. Payload only loads when a valid item enters a stage,
    // so a stalled output stays bit-for-bit stable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_chan   <= '0;
            out_sat    <= 1'b0;
            s1         <= '0;
            s2         <= '0;
        end else begin
            if (en1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1 <= '{sample: in_sample, chan: in_chan, mode: od_mode_e'(mode),
                            gain: gain, thresh: thresh};
                end
            end
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    s2 <= '{prod: prod_shr, sample: s1.sample, chan: s1.chan,
                            mode: s1.mode, thresh: s1.thresh};
                end
            end
            if (en3) begin
                out_valid <= v2;
                if (v2) begin
                    out_sample <= lim_value;
                    out_chan   <= s2.chan;
                    out_sat    <= lim_sat;
                end
            end
        end
    end

    // Clip statistics count at the output transfer, not at computation,
    // so a stalled clipped sample is counted exactly once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clip_count <= '0;
        end else if (clr_stats) begin
            clip_count <= '0;
        end else if (out_valid && out_ready && out_sat && (clip_count != '1)) begin
            clip_count <= clip_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_overdrive_pipe.sv
// Directed testbench for overdrive_pipe.
// Inputs change on the falling clock edge; outputs are sampled there too,
// half a cycle away from the rising edge the design uses.
module tb_overdrive_pipe;
    import overdrive_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        mode;
    logic [GAIN_W-1:0] gain;
    logic [DATA_W-2:0] thresh;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sample;
    logic [CHAN_W-1:0] in_chan;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sample;
    logic [CHAN_W-1:0] out_chan;
    logic [CNT_W-1:0]  clip_count;
    logic              clr_stats;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    overdrive_pipe dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .gain       (gain),
        .thresh     (thresh),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .in_chan    (in_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_chan   (out_chan),
        .clip_count (clip_count),
        .clr_stats  (clr_stats)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] s, input logic c);
        in_valid  = v;
        in_sample = s;
        in_chan   = c;
    endtask

    // Sends one sample at the current falling edge and checks it three cycles later.
    // Returns at the falling edge where the result is valid (not yet transferred).
    task automatic runSingle(input string tag, input logic [15:0] s, input logic c,
                             input logic [15:0] exp_s);
        applyStimulus(1'b1, s, c);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput(tag, 32'(out_sample), 32'(exp_s));
        checkOutput({tag, "_chan"}, 32'(out_chan), 32'(c));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] held_s;
        logic        holding;
        logic        saw_ready_low;
        logic        stale;
        int          sent;
        int          recv;

        reset_n   = 1'b0;
        mode      = 2'd1;
        gain      = 8'h20;
        thresh    = 15'h4000;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_sample", 32'(out_sample), 32'd0);
        checkOutput("rst_out_chan", 32'(out_chan), 32'd0);
        checkOutput("rst_clip_count", 32'(clip_count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Hard clip with gain 2.0
        $display("[TB] hard clip");
        mode = 2'd1;
        gain = 8'h20;
        runSingle("hard_3000", 16'h3000, 1'b0, 16'h6000);
        runSingle("hard_5000", 16'h5000, 1'b1, 16'h7FFF);
        runSingle("hard_B000", 16'hB000, 1'b0, 16'h8000);
        @(negedge clk);
        checkOutput("hard_count", 32'(clip_count), 32'd2);

        // Soft knee, T=0x4000
        $display("[TB] soft knee");
        mode   = 2'd2;
        thresh = 15'h4000;
        runSingle("soft_3000", 16'h3000, 1'b0, 16'h5000);
        runSingle("soft_D000", 16'hD000, 1'b1, 16'hB000);
        runSingle("soft_7000", 16'h7000, 1'b0, 16'h7FFF);
        @(negedge clk);
        checkOutput("soft_count", 32'(clip_count), 32'd3);

        // Fractional gain 1.5 with floor rounding, reserved mode, zero gain, zero threshold
        $display("[TB] rounding and corner cases");
        mode = 2'd1;
        gain = 8'h18;
        runSingle("frac_pos", 16'h0003, 1'b0, 16'h0004);
        runSingle("frac_neg", 16'hFFFD, 1'b1, 16'hFFFB);
        mode = 2'd3;
        gain = 8'h20;
        runSingle("rsvd_5000", 16'h5000, 1'b0, 16'h7FFF);
        mode = 2'd1;
        gain = 8'h00;
        runSingle("gain0", 16'h7FFF, 1'b1, 16'h0000);
        @(negedge clk);
        checkOutput("corner_count", 32'(clip_count), 32'd4);
        mode   = 2'd2;
        gain   = 8'h10;
        thresh = 15'h0000;
        runSingle("t0_pos", 16'h0101, 1'b0, 16'h0080);
        runSingle("t0_neg", 16'hFEFF, 1'b1, 16'hFF7F);
        @(negedge clk);

        // Streaming with output backpressure, gain 1.0 so out = in
        $display("[TB] streaming with backpressure");
        mode          = 2'd1;
        gain          = 8'h10;
        holding       = 1'b0;
        saw_ready_low = 1'b0;
        held_s        = 16'h0000;
        sent          = 0;
        recv          = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            if (sent < 8) begin
                applyStimulus(1'b1, 16'h0101 + 16'(sent), 1'(sent));
            end else begin
                applyStimulus(1'b0, 16'h0000, 1'b0);
            end
            #1;
            if (holding) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_hold", 32'(out_sample), 32'(held_s));
            end
            holding = 1'b0;
            if (out_valid && out_ready) begin
                checkOutput("stream_data", 32'(out_sample), 32'(16'h0101 + 16'(recv)));
                checkOutput("stream_chan", 32'(out_chan), 32'(recv & 1));
                recv++;
            end else if (out_valid) begin
                holding = 1'b1;
                held_s  = out_sample;
            end
            if (in_valid && !in_ready) saw_ready_low = 1'b1;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        checkOutput("stream_sent", 32'(sent), 32'd8);
        checkOutput("stream_recv", 32'(recv), 32'd8);
        checkOutput("stream_ready_low", 32'(saw_ready_low), 32'd1);
        checkOutput("stream_drained", 32'(out_valid), 32'd0);

        // Reset with three samples in flight
        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 16'h0011, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 16'h0022, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 16'h0033, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        out_ready = 1'b0;
        #1;
        checkOutput("inflight_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_sample", 32'(out_sample), 32'd0);
        checkOutput("midrst_chan", 32'(out_chan), 32'd0);
        checkOutput("midrst_count", 32'(clip_count), 32'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        stale     = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        checkOutput("no_stale", 32'(stale), 32'd0);
        runSingle("post_rst", 16'h0200, 1'b1, 16'h0200);

        // Bypass with large gain: exact passthrough, channel tags kept, no counting
        $display("[TB] bypass and stats clear");
        mode = 2'd0;
        gain = 8'h70;
        runSingle("byp_8000", 16'h8000, 1'b0, 16'h8000);
        runSingle("byp_7FFF", 16'h7FFF, 1'b1, 16'h7FFF);
        runSingle("byp_1234", 16'h1234, 1'b0, 16'h1234);
        @(negedge clk);
        checkOutput("byp_count", 32'(clip_count), 32'd0);

        // Clear coinciding with a counted transfer leaves zero
        mode = 2'd1;
        gain = 8'h20;
        runSingle("clr_pre", 16'h5000, 1'b0, 16'h7FFF);
        @(negedge clk);
        checkOutput("clr_pre_count", 32'(clip_count), 32'd1);
        runSingle("clr_xfer", 16'h6000, 1'b1, 16'h7FFF);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        checkOutput("clr_xfer_done", 32'(out_valid), 32'd0);
        checkOutput("clr_count", 32'(clip_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
